// File: rtl/ldpc_pkg.sv
// Shared types and helpers for the check-node message store: compressed entry
// layout and the offset-min-sum magnitude correction.
package ldpc_pkg;

  localparam int unsigned BITS        = 8;
  localparam int unsigned DMAX        = 10;
  localparam int unsigned LAYERS      = 4;
  localparam int unsigned OFFSET      = 1;
  localparam int unsigned INPUTS_BITS = $clog2(DMAX);
  localparam int unsigned LBITS       = $clog2(LAYERS);
  localparam int          MAX         = 2 ** (BITS - 1) - 1;

  typedef struct packed {
    logic                   valid;
    logic [BITS-1:0]        cmin1;
    logic [BITS-1:0]        cmin2;
    logic [INPUTS_BITS-1:0] idx;
    logic [DMAX-1:0]        signs;
  } cnm_entry_t;

  // Clamp a two's-complement magnitude to [0, MAX], then subtract off with floor at 0.
  function automatic logic [BITS-1:0] sat_sub(input logic [BITS-1:0] x,
                                               input int unsigned    off);
    int m;
    m = int'($signed(x));
    if (m < 0) m = 0;
    if (m > MAX) m = MAX;
    m = m - int'(off);
    if (m < 0) m = 0;
    return m[BITS-1:0];
  endfunction

endpackage

// File: rtl/beta_regen.sv
// Expands a compressed check-node entry into per-edge signed messages.
module beta_regen
  import ldpc_pkg::*;
(
  input  cnm_entry_t             i_entry,
  output logic [DMAX*BITS-1:0]   o_beta
);

  logic            w_parity;
  logic            w_sign;
  logic [BITS-1:0] w_mag;

  always_comb begin
    o_beta   = '0;
    w_sign   = 1'b0;
    w_mag    = '0;
    w_parity = ^i_entry.signs;
    if (i_entry.valid) begin
      // An idx beyond the last edge never matches, so every edge takes cmin1.
      for (int unsigned e = 0; e < DMAX; e++) begin
        w_sign = w_parity ^ i_entry.signs[e];
        w_mag  = (e == 32'(i_entry.idx)) ? i_entry.cmin2 : i_entry.cmin1;
        o_beta[e*BITS +: BITS] = w_sign ? (-w_mag) : w_mag;
      end
    end
  end

endmodule

// File: rtl/cnm_store_regen.sv
// Per-layer compressed check-message store with offset-min-sum correction and
// regeneration of fresh (beta_new) and previous-iteration (beta_old) messages.
module cnm_store_regen
  import ldpc_pkg::*;
#(
  parameter int unsigned P_BITS        = ldpc_pkg::BITS,
  parameter int unsigned P_DMAX        = ldpc_pkg::DMAX,
  parameter int unsigned P_LAYERS      = ldpc_pkg::LAYERS,
  parameter int unsigned P_OFFSET      = ldpc_pkg::OFFSET,
  parameter int unsigned P_INPUTS_BITS = $clog2(P_DMAX),
  parameter int unsigned P_LBITS       = $clog2(P_LAYERS)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_clear,
  input  logic                       i_wr_valid,
  input  logic [P_LBITS-1:0]         i_wr_layer,
  input  logic [P_BITS-1:0]          i_min1,
  input  logic [P_BITS-1:0]          i_min2,
  input  logic [P_INPUTS_BITS-1:0]   i_idx_min,
  input  logic [P_DMAX-1:0]          i_signs,
  input  logic                       i_rd_valid,
  input  logic [P_LBITS-1:0]         i_rd_layer,
  output logic [P_DMAX*P_BITS-1:0]   o_beta_new,
  output logic                       o_beta_new_valid,
  output logic [P_DMAX*P_BITS-1:0]   o_beta_old,
  output logic                       o_beta_old_valid
);

  cnm_entry_t r_mem [P_LAYERS];

  cnm_entry_t                 w_fresh;
  cnm_entry_t                 w_rd_entry;
  logic                       w_wr_in_range;
  logic                       w_rd_in_range;
  logic [P_DMAX*P_BITS-1:0]   w_beta_fresh;
  logic [P_DMAX*P_BITS-1:0]   w_beta_rd;

  always_comb begin
    w_fresh       = '0;
    w_fresh.valid = 1'b1;
    w_fresh.cmin1 = sat_sub(i_min1, P_OFFSET);
    w_fresh.cmin2 = sat_sub(i_min2, P_OFFSET);
    w_fresh.idx   = i_idx_min;
    w_fresh.signs = i_signs;

    w_wr_in_range = 32'(i_wr_layer) < P_LAYERS;
    w_rd_in_range = 32'(i_rd_layer) < P_LAYERS;

    // Out-of-range layers read as an invalid entry, which regenerates to zeros.
    w_rd_entry = '0;
    if (w_rd_in_range) w_rd_entry = r_mem[i_rd_layer];
  end

  beta_regen u_regen_new (
    .i_entry (w_fresh),
    .o_beta  (w_beta_fresh)
  );

  beta_regen u_regen_old (
    .i_entry (w_rd_entry),
    .o_beta  (w_beta_rd)
  );

  // Clear invalidates first; a same-cycle write then overrides its own slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < P_LAYERS; i++) r_mem[i] <= '0;
    end else begin
      if (i_clear) begin
        for (int unsigned i = 0; i < P_LAYERS; i++) r_mem[i].valid <= 1'b0;
      end
      if (i_wr_valid && w_wr_in_range) r_mem[i_wr_layer] <= w_fresh;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_beta_new       <= '0;
      o_beta_new_valid <= 1'b0;
      o_beta_old       <= '0;
      o_beta_old_valid <= 1'b0;
    end else begin
      o_beta_new_valid <= i_wr_valid;
      o_beta_old_valid <= i_rd_valid;
      if (i_wr_valid) o_beta_new <= w_beta_fresh;
      if (i_rd_valid) o_beta_old <= w_beta_rd;
    end
  end

endmodule
